mips_state_dump: RTL and testbench
==================================

MIPS_STATE_DUMP -- requirements
Module: mips_state_dump

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register, memory word and PC width.
REQ-002 The block SHALL have parameter REG_COUNT, default 32, meaning registers dumped, indices 0..REG_COUNT-1 (max 32).
REQ-003 The block SHALL have parameter MEM_WORDS, default 12, meaning data-memory words dumped.
REQ-004 The block SHALL have parameter MEM_BASE, default 0, meaning byte address of the first dumped word.
REQ-005 The block SHALL have parameter HALT_CYCLES, default 8, meaning cycles of unchanged PC that trigger an automatic dump (0 disables auto-trigger).
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1, manual dump request sampled in IDLE.
REQ-009 The block SHALL have port pc_in, input, DATA_W, the CPU program counter.
REQ-010 The block SHALL have port rf_raddr, output, 5, register-file read index.
REQ-011 The block SHALL have port rf_rdata, input, DATA_W, combinational register-file read data.
REQ-012 The block SHALL have port dm_addr, output, 32, data-memory byte address, word aligned.
REQ-013 The block SHALL have port dm_rdata, input, DATA_W, combinational big-endian word read at dm_addr.
REQ-014 The block SHALL have port dout, output, DATA_W, record payload.
REQ-015 The block SHALL have port dout_kind, output, 2, record type: 0=PC, 1=REG, 2=MEM.
REQ-016 The block SHALL have port dout_index, output, 8, register number or memory word number.
REQ-017 The block SHALL have ports dout_valid (output, 1) and dout_ready (input, 1), the record handshake.
REQ-018 The block SHALL have ports busy (output, 1), high outside IDLE, and done (output, 1), a one-cycle end pulse.

Function
REQ-019 The FSM SHALL have states IDLE, PC, REGS, MEM and DONE.
REQ-020 A dump SHALL start from IDLE when start=1, or when auto-trigger fires.
REQ-021 On start, the next state SHALL be PC, loading dout=pc_in as sampled at the start edge, with kind 0, index 0 and dout_valid=1.
REQ-022 While dout_valid=1 and dout_ready=0, dout, dout_kind and dout_index SHALL hold stable.
REQ-023 On each handshake (valid and ready), the next record SHALL load on the same edge with no bubble: REG i carries rf_rdata with rf_raddr=i; MEM j carries dm_rdata with dm_addr=MEM_BASE+4*j.
REQ-024 The record order SHALL be PC, REG 0..REG_COUNT-1, then MEM 0..MEM_WORDS-1, for 1+REG_COUNT+MEM_WORDS records in total.
REQ-025 If REG_COUNT=0 or MEM_WORDS=0, that section SHALL be skipped.
REQ-026 rf_raddr and dm_addr SHALL be driven from the internal index ahead of the loading edge; values outside their active section are don't-care.
REQ-027 On the handshake of the final record, dout_valid SHALL drop, the state SHALL move to DONE, and done=1 SHALL assert for exactly one cycle before returning to IDLE.
REQ-028 start SHALL be ignored while busy=1; a held start SHALL begin a new dump in the cycle after DONE.
REQ-029 The auto-trigger counter SHALL count consecutive cycles where pc_in equals its previous-cycle value, saturating, and clearing on any change.
REQ-030 The auto-trigger SHALL fire when the counter reaches HALT_CYCLES and armed=1.
REQ-031 Firing SHALL clear armed; armed SHALL be set again only when pc_in changes.
REQ-032 If start and auto-trigger occur together, a single dump SHALL start and armed SHALL be cleared.

Reset
REQ-033 rst=1 SHALL force at once: state IDLE, dout=0, dout_kind=0, dout_index=0, dout_valid=0, busy=0, done=0, rf_raddr=0, dm_addr=MEM_BASE, counter=0, previous-PC register=0, armed=1.
REQ-034 Reset mid-dump SHALL abort without a done pulse, and the next dump SHALL restart at the PC record.

Verification
REQ-035 Defaults, dout_ready=1, start at cycle 0 -> dout_valid high cycles 1..45 (PC, 32 REG, 12 MEM), done=1 only at cycle 46, busy low at cycle 47.
REQ-036 RF preloaded Ri=i*3, DM word j=32'h1000+j, pc_in=32'h40 -> records in order: 40, 0, 3, ..., 93, then 1000..100B with dm_addr 0..44.
REQ-037 dout_ready toggled at random during a dump -> no record lost or duplicated, payload stable while stalled, 45 handshakes total.
REQ-038 pc_in held at 32'h5C for 20 cycles with start=0 -> exactly one dump begins after 8 stable cycles; pc_in then changes and holds 8 cycles -> a second dump fires.
REQ-039 rst asserted at REG 10 mid-dump -> all outputs read zero at once with no done pulse; a following start emits the PC record first.
REQ-040 MEM_WORDS=0, REG_COUNT=4 -> 5 records, done pulse after REG 3, no dm_addr dependence.

Source files
------------

// File: rtl/mips_state_dump.sv
// mips_state_dump: streams a snapshot of CPU state as PC, register and memory records.
// A dump starts on a manual request or once the PC has stayed unchanged for
// HALT_CYCLES cycles. Records are handed out over a valid/ready handshake.
module mips_state_dump #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_COUNT   = 32,
  parameter int unsigned MEM_WORDS   = 12,
  parameter int unsigned MEM_BASE    = 0,
  parameter int unsigned HALT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pc_in,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        dout_kind,
  output logic [7:0]        dout_index,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_PC, S_REGS, S_MEM, S_DONE} state_t;

  localparam logic [1:0] KIND_PC  = 2'd0;
  localparam logic [1:0] KIND_REG = 2'd1;
  localparam logic [1:0] KIND_MEM = 2'd2;

  localparam logic [7:0] LAST_REG = (REG_COUNT > 0) ? 8'(REG_COUNT - 1) : 8'd0;
  localparam logic [7:0] LAST_MEM = (MEM_WORDS > 0) ? 8'(MEM_WORDS - 1) : 8'd0;

  localparam int unsigned    CNT_W   = (HALT_CYCLES < 2) ? 1 : $clog2(HALT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALT_CYCLES);

  state_t              state;
  state_t              state_next;
  logic [7:0]          nidx;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   prev_pc;
  logic                armed;
  logic                hs;
  logic                auto_hit;
  logic                trigger;
  logic                load_reg;
  logic                load_mem;

  assign hs       = dout_valid && dout_ready;
  assign auto_hit = (HALT_CYCLES != 0) && armed && (cnt == CNT_MAX);
  assign trigger  = (state == S_IDLE) && (start || auto_hit);
  assign load_reg = hs && (state_next == S_REGS);
  assign load_mem = hs && (state_next == S_MEM);

  // nidx always names the record that the next handshake loads, so the
  // memory interfaces see their address one cycle ahead of the load edge.
  assign rf_raddr = nidx[4:0];
  assign dm_addr  = 32'(MEM_BASE) + {22'd0, nidx, 2'b00};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state selection; empty sections are skipped.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (trigger) state_next = S_PC;
      S_PC: begin
        if (hs) begin
          if (REG_COUNT > 0)      state_next = S_REGS;
          else if (MEM_WORDS > 0) state_next = S_MEM;
          else                    state_next = S_DONE;
        end
      end
      S_REGS: begin
        if (hs && (dout_index == LAST_REG)) begin
          if (MEM_WORDS > 0) state_next = S_MEM;
          else               state_next = S_DONE;
        end
      end
      S_MEM:  if (hs && (dout_index == LAST_MEM)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from state; valid is high for every record state.
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    dout_valid = (state == S_PC) || (state == S_REGS) || (state == S_MEM);
  end

  // Record register: loads on the start edge and on each handshake, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_kind  <= KIND_PC;
      dout_index <= '0;
      nidx       <= '0;
    end else if (trigger) begin
      dout       <= pc_in;
      dout_kind  <= KIND_PC;
      dout_index <= '0;
      nidx       <= '0;
    end else if (load_reg) begin
      dout       <= rf_rdata;
      dout_kind  <= KIND_REG;
      dout_index <= nidx;
      // Wrap to 0 after the last register so dm_addr already points at word 0.
      nidx       <= (nidx == LAST_REG) ? 8'd0 : nidx + 8'd1;
    end else if (load_mem) begin
      dout       <= dm_rdata;
      dout_kind  <= KIND_MEM;
      dout_index <= nidx;
      nidx       <= nidx + 8'd1;
    end
  end

  // Halt detector: saturating count of unchanged-PC cycles plus one-shot arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pc <= '0;
      cnt     <= '0;
      armed   <= 1'b1;
    end else begin
      prev_pc <= pc_in;
      if (pc_in != prev_pc) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if ((state == S_IDLE) && auto_hit) armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_state_dump.sv
// tb_mips_state_dump: randomized and directed checks of mips_state_dump against
// a record-position reference model.
module tb_mips_state_dump;

  localparam int NREG = 32;
  localparam int NMEM = 12;
  localparam int NREC = 1 + NREG + NMEM;
  localparam int HALT = 8;

  localparam int PH_IDLE = 0;
  localparam int PH_DUMP = 1;
  localparam int PH_DONE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_in = '0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] dm_addr;
  logic [31:0] dm_rdata;
  logic [31:0] dout;
  logic [1:0]  dout_kind;
  logic [7:0]  dout_index;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        busy;
  logic        done;

  logic        start2 = 1'b0;
  logic [31:0] pc2 = 32'h1234;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata2;
  logic [31:0] dm_addr2;
  logic [31:0] dout2;
  logic [1:0]  dout_kind2;
  logic [7:0]  dout_index2;
  logic        dout_valid2;
  logic        busy2;
  logic        done2;

  logic [31:0] rf [32];
  logic [31:0] dm [64];

  int checks = 0;
  int errors = 0;

  assign rf_rdata  = rf[rf_raddr];
  assign dm_rdata  = dm[dm_addr[7:2]];
  assign rf_rdata2 = rf[rf_raddr2];

  mips_state_dump #(
    .DATA_W(32), .REG_COUNT(NREG), .MEM_WORDS(NMEM), .MEM_BASE(0), .HALT_CYCLES(HALT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_addr(dm_addr), .dm_rdata(dm_rdata),
    .dout(dout), .dout_kind(dout_kind), .dout_index(dout_index),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  mips_state_dump #(
    .DATA_W(32), .REG_COUNT(4), .MEM_WORDS(0), .MEM_BASE(0), .HALT_CYCLES(0)
  ) dut_small (
    .clk(clk), .rst(rst), .start(start2), .pc_in(pc2),
    .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata2), .dm_addr(dm_addr2), .dm_rdata(32'hDEADBEEF),
    .dout(dout2), .dout_kind(dout_kind2), .dout_index(dout_index2),
    .dout_valid(dout_valid2), .dout_ready(1'b1), .busy(busy2), .done(done2)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: a dump is a list of NREC records addressed by position.
  int          m_phase = PH_IDLE;
  int          m_pos = 0;
  logic [31:0] m_snap = '0;
  logic [31:0] m_prev = '0;
  int          m_cnt = 0;
  bit          m_armed = 1'b1;
  bit          m_hit;
  bit          m_was_idle;

  function automatic logic [41:0] exp_rec(input int p);
    if (p == 0)         return {2'd0, 8'd0, m_snap};
    else if (p <= NREG) return {2'd1, 8'(p - 1), rf[p - 1]};
    else                return {2'd2, 8'(p - 1 - NREG), dm[p - 1 - NREG]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = PH_IDLE; m_pos = 0; m_snap = '0; m_prev = '0; m_cnt = 0; m_armed = 1'b1;
    end else begin
      m_hit      = (m_cnt == HALT) && m_armed;
      m_was_idle = (m_phase == PH_IDLE);
      case (m_phase)
        PH_IDLE: if (start || m_hit) begin m_phase = PH_DUMP; m_pos = 0; m_snap = pc_in; end
        PH_DUMP: if (dout_ready) begin
          if (m_pos == NREC - 1) m_phase = PH_DONE;
          else m_pos++;
        end
        default: m_phase = PH_IDLE;
      endcase
      if (pc_in != m_prev) begin
        m_cnt = 0; m_armed = 1'b1;
      end else begin
        if (m_cnt < HALT) m_cnt++;
        if (m_was_idle && m_hit) m_armed = 1'b0;
      end
      m_prev = pc_in;
    end
  end

  int hs_cnt = 0;
  int starts = 0;
  int dones = 0;
  bit busy_q = 1'b0;

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (rst) begin
      hs_cnt = 0;
      busy_q = 1'b0;
    end else begin
      check("ctl", {dout_valid, busy, done},
            {m_phase == PH_DUMP, m_phase != PH_IDLE, m_phase == PH_DONE});
      if (m_phase == PH_DUMP) check("rec", {dout_kind, dout_index, dout}, exp_rec(m_pos));
      if (dout_valid && dout_ready) hs_cnt++;
      if (done) begin
        check("hs_total", hs_cnt, NREC);
        hs_cnt = 0;
        dones++;
      end
      if (busy && !busy_q) starts++;
      busy_q = busy;
    end
  end

  task automatic wait_idle(input int lim);
    int n = 0;
    while (m_phase != PH_IDLE && n < lim) begin
      pc_in = pc_in + 32'd4;
      tick();
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    int base;
    logic [31:0] pc_at_start;

    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
    for (int j = 0; j < 64; j++) dm[j] = 32'h1000 + 32'(j);

    // Reset values.
    #1 rst = 1'b1;
    #1;
    check("rst_dout", dout, 0);
    check("rst_kind", dout_kind, 0);
    check("rst_index", dout_index, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_raddr", rf_raddr, 0);
    check("rst_dmaddr", dm_addr, 0);
    check("rst_small", {dout_valid2, busy2, done2, dm_addr2}, 0);
    tick();
    tick();
    rst = 1'b0;

    // Full dump with ready held high: timing and record order.
    pc_in = 32'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 47; c++) begin
      check("t_vdb", {dout_valid, done, busy}, {(c >= 1 && c <= 45), (c == 46), (c <= 46)});
      if (c == 1)  check("t_pc", dout, 32'h40);
      if (c == 33) check("t_dm0", dm_addr, 32'd0);
      if (c == 34) check("t_mem0", dout, 32'h1000);
      if (c == 45) check("t_mem11", {dout_kind, dout_index, dout}, {2'd2, 8'd11, 32'h100B});
      pc_in = pc_in + 32'd4;
      tick();
    end
    wait_idle(10);

    // Random stalls with random contents.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int j = 0; j < 64; j++) dm[j] = $urandom;
      pc_in = $urandom & 32'hFFFF_FFFC;
      start = 1'b1;
      dout_ready = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      for (int n = 0; n < 400 && m_phase != PH_IDLE; n++) begin
        dout_ready = 1'($urandom_range(0, 1));
        pc_in = pc_in + 32'd4;
        tick();
      end
      dout_ready = 1'b1;
      wait_idle(10);
    end

    // Held start: back-to-back dumps, one idle cycle apart.
    base = dones;
    start = 1'b1;
    for (int n = 0; n < 100; n++) begin
      pc_in = pc_in + 32'd4;
      tick();
    end
    check("held_start_dones", dones - base, 2);
    start = 1'b0;
    wait_idle(100);

    // Auto trigger on a stalled PC.
    base = starts;
    pc_in = 32'h5C;
    for (int n = 0; n < 20; n++) tick();
    check("auto_first", starts - base, 1);
    pc_in = 32'h60;
    for (int n = 0; n < 120; n++) tick();
    check("auto_second", starts - base, 2);
    check("auto_idle", busy, 1'b0);

    // Reset in the middle of the register section.
    pc_in = 32'h200;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 100 && !(m_phase == PH_DUMP && m_pos == 11); n++) begin
      pc_in = pc_in + 32'd4;
      tick();
    end
    check("mid_reg10", {dout_kind, dout_index}, {2'd1, 8'd10});
    rst = 1'b1;
    #1;
    check("mid_rst_out", {dout, dout_kind, dout_index, dout_valid, busy, done}, 0);
    check("mid_rst_addr", {rf_raddr, dm_addr}, 0);
    tick();
    check("mid_rst_nodone", {done, busy}, 0);
    rst = 1'b0;
    pc_in = 32'h300;
    pc_at_start = pc_in;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_pc", {dout_valid, dout_kind, dout_index, dout}, {1'b1, 2'd0, 8'd0, pc_at_start});
    wait_idle(100);

    // Register-only configuration.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check("s_vdb", {dout_valid2, done2, busy2}, {(c <= 5), (c == 6), (c <= 6)});
      if (c == 1) check("s_pc", {dout_kind2, dout_index2, dout2}, {2'd0, 8'd0, 32'h1234});
      else if (c <= 5) check("s_reg", {dout_kind2, dout_index2, dout2}, {2'd1, 8'(c - 2), rf[c - 2]});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
